// File: rtl/misr_test_ctrl.sv
// Sequences one MISR signature test over a simple bus: clear, program, run, read back, compare.
// Latency: done_o pulses 7+ncyc cycles after an accepted start.
// Backpressure: none; start_i while busy and host requests outside RUN are dropped.
module misr_test_ctrl #(
    parameter int          NBIT_DATA  = 64,
    parameter int          NBIT_ADDR  = 64,
    parameter logic [63:0] START_ADDR = 64'h0000_0000_0200_0000,
    parameter int          CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [NBIT_DATA-1:0] coeff_i,
    input  logic [NBIT_DATA-1:0] golden_i,
    input  logic [CNT_W-1:0]     ncyc_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [NBIT_DATA-1:0] sig_o,
    input  logic                 h_re_i,
    input  logic                 h_we_i,
    input  logic [NBIT_ADDR-1:0] h_addr_i,
    input  logic [NBIT_DATA-1:0] h_wdata_i,
    output logic                 h_gnt_o,
    output logic                 re_o,
    output logic                 we_o,
    output logic [NBIT_ADDR-1:0] addr_o,
    output logic [NBIT_DATA-1:0] wdata_o,
    input  logic [NBIT_DATA-1:0] rdata_i
);

    localparam logic [NBIT_ADDR-1:0] CTRL_ADDR = NBIT_ADDR'(START_ADDR);
    localparam logic [NBIT_ADDR-1:0] COEF_ADDR = NBIT_ADDR'(START_ADDR + 64'h40);
    localparam logic [NBIT_ADDR-1:0] SIG_ADDR  = NBIT_ADDR'(START_ADDR + 64'h80);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_COEF, S_EN, S_RUN, S_RD_SIG, S_CAP, S_DIS, S_FIN
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     ncyc_q;
    logic [NBIT_DATA-1:0] coeff_q;
    logic [NBIT_DATA-1:0] golden_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ncyc_q   <= '0;
            coeff_q  <= '0;
            golden_q <= '0;
            sig_o    <= '0;
            pass_o   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        coeff_q  <= coeff_i;
                        golden_q <= golden_i;
                        ncyc_q   <= ncyc_i;
                        pass_o   <= 1'b0;
                    end
                end
                S_EN:  cnt <= ncyc_q;
                S_RUN: cnt <= cnt - CNT_W'(1);
                S_CAP: begin
                    // rdata_i answers the read issued in RD_SIG one cycle earlier
                    sig_o  <= rdata_i;
                    pass_o <= (rdata_i == golden_q);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = (state != S_IDLE);
        done_o    = 1'b0;
        h_gnt_o   = 1'b0;
        re_o      = 1'b0;
        we_o      = 1'b0;
        addr_o    = '0;
        wdata_o   = '0;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_CLR;
            end
            S_CLR: begin
                re_o      = 1'b1;
                we_o      = 1'b1;
                addr_o    = CTRL_ADDR;
                wdata_o   = NBIT_DATA'(3);
                state_nxt = S_COEF;
            end
            S_COEF: begin
                re_o      = 1'b1;
                we_o      = 1'b1;
                addr_o    = COEF_ADDR;
                wdata_o   = coeff_q;
                state_nxt = S_EN;
            end
            S_EN: begin
                re_o      = 1'b1;
                we_o      = 1'b1;
                addr_o    = CTRL_ADDR;
                wdata_o   = NBIT_DATA'(1);
                state_nxt = (ncyc_q == '0) ? S_RD_SIG : S_RUN;
            end
            S_RUN: begin
                h_gnt_o = 1'b1;
                re_o    = h_re_i;
                we_o    = h_we_i;
                addr_o  = h_addr_i;
                wdata_o = h_wdata_i;
                // last compaction cycle when the counter is at 1
                if (cnt == CNT_W'(1)) state_nxt = S_RD_SIG;
            end
            S_RD_SIG: begin
                re_o      = 1'b1;
                addr_o    = SIG_ADDR;
                state_nxt = S_CAP;
            end
            S_CAP: state_nxt = S_DIS;
            S_DIS: begin
                re_o      = 1'b1;
                we_o      = 1'b1;
                addr_o    = CTRL_ADDR;
                state_nxt = S_FIN;
            end
            S_FIN: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_misr_test_ctrl.sv
// Bench for misr_test_ctrl: table of tests plus random host traffic, checked cycle by cycle.
module tb_misr_test_ctrl;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [63:0] coeff_i, golden_i;
    logic [15:0] ncyc_i;
    logic        busy_o, done_o, pass_o;
    logic [63:0] sig_o;
    logic        h_re_i, h_we_i;
    logic [63:0] h_addr_i, h_wdata_i;
    logic        h_gnt_o;
    logic        re_o, we_o;
    logic [63:0] addr_o, wdata_o, rdata_i;

    always #5 clk_i = ~clk_i;

    misr_test_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .coeff_i(coeff_i), .golden_i(golden_i), .ncyc_i(ncyc_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .sig_o(sig_o),
        .h_re_i(h_re_i), .h_we_i(h_we_i), .h_addr_i(h_addr_i), .h_wdata_i(h_wdata_i),
        .h_gnt_o(h_gnt_o), .re_o(re_o), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .rdata_i(rdata_i)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        gnt;
        logic        re;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } obs_t;

    typedef struct {
        logic [63:0] coeff;
        logic [63:0] golden;
        logic [63:0] rval;
        int          ncyc;
        logic        exp_pass;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs[9];

    function automatic obs_t sample();
        obs_t o;
        o.busy  = busy_o;
        o.done  = done_o;
        o.gnt   = h_gnt_o;
        o.re    = re_o;
        o.we    = we_o;
        o.addr  = addr_o;
        o.wdata = wdata_o;
        return o;
    endfunction

    task automatic chk_obs(input string nm, input int k, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got busy=%b done=%b gnt=%b re=%b we=%b addr=%h wdata=%h want busy=%b done=%b gnt=%b re=%b we=%b addr=%h wdata=%h",
                     nm, k, act.busy, act.done, act.gnt, act.re, act.we, act.addr, act.wdata,
                     exp.busy, exp.done, exp.gnt, exp.re, exp.we, exp.addr, exp.wdata);
        end
    endtask

    task automatic chk_val(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, k, act, exp);
        end
    endtask

    task automatic rand_host();
        h_re_i    = 1'($urandom_range(0, 1));
        h_we_i    = 1'($urandom_range(0, 1));
        h_addr_i  = {$urandom, $urandom};
        h_wdata_i = {$urandom, $urandom};
    endtask

    // Expected bus activity for cycle k after the start edge, derived from the test's write/run/read plan.
    function automatic obs_t expect_cycle(input int k, input int n, input logic [63:0] coeff);
        obs_t e;
        e = '0;
        e.busy = (k <= 7 + n);
        e.done = (k == 7 + n);
        if (k == 1) begin
            e.re = 1'b1; e.we = 1'b1; e.addr = BASE;          e.wdata = 64'h3;
        end else if (k == 2) begin
            e.re = 1'b1; e.we = 1'b1; e.addr = BASE + 64'h40; e.wdata = coeff;
        end else if (k == 3) begin
            e.re = 1'b1; e.we = 1'b1; e.addr = BASE;          e.wdata = 64'h1;
        end else if (k >= 4 && k <= 3 + n) begin
            e.gnt = 1'b1; e.re = h_re_i; e.we = h_we_i; e.addr = h_addr_i; e.wdata = h_wdata_i;
        end else if (k == 4 + n) begin
            e.re = 1'b1; e.addr = BASE + 64'h80;
        end else if (k == 6 + n) begin
            e.re = 1'b1; e.we = 1'b1; e.addr = BASE;
        end
        return e;
    endfunction

    // Runs one full test from IDLE; inputs other than host stay noisy while busy.
    task automatic run_test(input vec_t v);
        int n;
        n = v.ncyc;
        start_i  = 1'b1;
        coeff_i  = v.coeff;
        golden_i = v.golden;
        ncyc_i   = 16'(v.ncyc);
        @(posedge clk_i); #1;
        for (int k = 1; k <= 8 + n; k++) begin
            rand_host();
            start_i  = (k <= 7 + n) ? 1'($urandom_range(0, 1)) : 1'b0;
            coeff_i  = {$urandom, $urandom};
            golden_i = {$urandom, $urandom};
            ncyc_i   = 16'($urandom);
            rdata_i  = (k == 5 + n) ? v.rval : {$urandom, $urandom};
            @(negedge clk_i);
            chk_obs("bus", k, sample(), expect_cycle(k, n, v.coeff));
            chk_val("pass", k, {63'd0, pass_o}, {63'd0, (k >= 6 + n) ? v.exp_pass : 1'b0});
            if (k >= 6 + n) chk_val("sig", k, sig_o, v.rval);
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
    endtask

    initial begin
        logic [63:0] x;
        obs_t        zero_obs;
        zero_obs = '0;
        x = 64'hDEAD_BEEF_0123_4567;

        vecs[0] = '{coeff: 64'hB, golden: x, rval: x,           ncyc: 3,  exp_pass: 1'b1};
        vecs[1] = '{coeff: 64'hB, golden: x, rval: x ^ 64'h1,   ncyc: 3,  exp_pass: 1'b0};
        vecs[2] = '{coeff: 64'hB, golden: x, rval: x,           ncyc: 0,  exp_pass: 1'b1};
        vecs[3] = '{coeff: 64'h1D, golden: 64'h5A, rval: 64'h5A, ncyc: 1, exp_pass: 1'b1};
        vecs[4] = '{coeff: 64'hFFFF_0000_FFFF_0001, golden: ~x, rval: ~x, ncyc: 65, exp_pass: 1'b1};
        for (int i = 5; i < 9; i++) begin
            vecs[i].coeff  = {$urandom, $urandom};
            vecs[i].golden = {$urandom, $urandom};
            vecs[i].rval   = ($urandom_range(0, 1) == 1) ? vecs[i].golden : {$urandom, $urandom};
            vecs[i].ncyc   = int'($urandom_range(0, 20));
            vecs[i].exp_pass = (vecs[i].rval == vecs[i].golden);
        end

        rst_ni = 1'b0; start_i = 1'b0; coeff_i = '0; golden_i = '0; ncyc_i = '0;
        h_re_i = 1'b0; h_we_i = 1'b0; h_addr_i = '0; h_wdata_i = '0; rdata_i = '0;
        #12;
        chk_obs("reset_bus", 0, sample(), zero_obs);
        chk_val("reset_pass", 0, {63'd0, pass_o}, 64'd0);
        chk_val("reset_sig", 0, sig_o, 64'd0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 9; i++) run_test(vecs[i]);

        // Reset in the middle of a long RUN must abort with no disable write.
        start_i = 1'b1; coeff_i = 64'h77; golden_i = 64'h99; ncyc_i = 16'd10;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            rand_host();
            @(posedge clk_i); #1;
        end
        h_re_i = 1'b1; h_we_i = 1'b1; h_addr_i = {$urandom, $urandom}; h_wdata_i = {$urandom, $urandom};
        #1;
        chk_obs("pre_reset_gnt", 6, sample(), expect_cycle(6, 10, 64'h77));
        rst_ni = 1'b0;
        #1;
        chk_obs("async_reset_bus", 6, sample(), zero_obs);
        chk_val("async_reset_pass", 6, {63'd0, pass_o}, 64'd0);
        chk_val("async_reset_sig", 6, sig_o, 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1; rand_host();
            @(negedge clk_i);
            chk_obs("held_reset_bus", k, sample(), zero_obs);
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1; rand_host();
            @(negedge clk_i);
            chk_obs("post_reset_idle", k, sample(), zero_obs);
        end
        @(posedge clk_i); #1;
        run_test(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
